// File: rtl/gbuf_burst_ctrl_pkg.sv
// Shared accelerator types: global-buffer command opcodes, command record and controller states.
package accelerator_package;

  localparam int unsigned GBUF_REGION_W = 2;
  localparam int unsigned GBUF_LEN_W    = 8;

  typedef enum logic [1:0] {
    OP_NOP       = 2'd0,
    OP_WRITE     = 2'd1,
    OP_READ      = 2'd2,
    OP_PTR_RESET = 2'd3
  } gbuf_op_t;

  typedef struct packed {
    gbuf_op_t                 op;
    logic                     src;
    logic [GBUF_REGION_W-1:0] region;
    logic [GBUF_LEN_W-1:0]    len;
  } gbuf_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN
  } gbuf_state_t;

endpackage

// File: rtl/gbuf_burst_ctrl_ram.sv
// Single-port word RAM (write or read per cycle) with a RD_LATENCY-deep read pipeline.
module gbuf_ram #(
  parameter int unsigned W          = 128,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [W-1:0]      wdata,
  output logic [W-1:0]      rdata,
  output logic              rvalid
);

  logic [W-1:0]          mem [DEPTH];
  logic [W-1:0]          data_pipe [RD_LATENCY];
  logic [RD_LATENCY-1:0] valid_pipe;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) data_pipe[0] <= mem[addr];
    for (int unsigned i = 1; i < RD_LATENCY; i++) data_pipe[i] <= data_pipe[i-1];
  end

  // Only the valid bits are reset; stale data behind them is never consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_pipe <= '0;
    end else begin
      valid_pipe[0] <= re;
      for (int unsigned i = 1; i < RD_LATENCY; i++) valid_pipe[i] <= valid_pipe[i-1];
    end
  end

  assign rdata  = data_pipe[RD_LATENCY-1];
  assign rvalid = valid_pipe[RD_LATENCY-1];

endmodule

// File: rtl/gbuf_burst_ctrl.sv
// Burst-command global buffer: per-region circular pointers, write streams into RAM,
// credit-guarded skid FIFO on the read stream.
module gbuf_burst_ctrl
  import accelerator_package::*;
#(
  parameter  int unsigned DATA_W      = 8,
  parameter  int unsigned LANES       = 16,
  parameter  int unsigned DEPTH       = 1024,
  parameter  int unsigned ADDR_W      = $clog2(DEPTH),
  parameter  int unsigned NUM_REGIONS = 4,
  parameter  int unsigned LEN_W       = 8,
  parameter  int unsigned RD_LATENCY  = 1,
  localparam int unsigned W           = DATA_W * LANES,
  localparam int unsigned REG_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  gbuf_op_t                      cmd_op_i,
  input  logic                          cmd_src_i,
  input  logic [REG_W-1:0]              cmd_region_i,
  input  logic [LEN_W-1:0]              cmd_len_i,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_base_i,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_size_i,
  input  logic                          ext_wr_valid_i,
  output logic                          ext_wr_ready_o,
  input  logic [W-1:0]                  ext_wr_data_i,
  input  logic                          obuf_wr_valid_i,
  output logic                          obuf_wr_ready_o,
  input  logic [W-1:0]                  obuf_wr_data_i,
  output logic                          rd_valid_o,
  input  logic                          rd_ready_i,
  output logic [W-1:0]                  rd_data_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int unsigned FIFO_DEPTH = RD_LATENCY + 1;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  gbuf_state_t       state_q, state_n;
  logic [ADDR_W-1:0] head_q [NUM_REGIONS];
  logic [REG_W-1:0]  region_q, cur_region;
  logic              src_q, done_q, done_d;
  logic [LEN_W-1:0]  remaining_q, rem_cur;
  logic [CNT_W-1:0]  fifo_count_q, inflight_q;
  logic [PTR_W-1:0]  fifo_wr_q, fifo_rd_q;
  logic [W-1:0]      fifo_mem [FIFO_DEPTH];

  logic              cmd_fire, wr_beat, rd_issue, push, pop, credit_ok, drain_done;
  logic [ADDR_W-1:0] base_cur, size_cur, head_cur, head_adv, ram_addr;
  logic [W-1:0]      ram_rdata, wr_data;

  assign cmd_ready_o     = (state_q == ST_IDLE);
  assign busy_o          = (state_q != ST_IDLE);
  assign cmd_fire        = cmd_valid_i & cmd_ready_o;
  assign ext_wr_ready_o  = (state_q == ST_WRITE) && !src_q && (remaining_q != '0);
  assign obuf_wr_ready_o = (state_q == ST_WRITE) &&  src_q && (remaining_q != '0);
  assign wr_beat         = src_q ? (obuf_wr_valid_i & obuf_wr_ready_o)
                                 : (ext_wr_valid_i & ext_wr_ready_o);
  assign wr_data         = src_q ? obuf_wr_data_i : ext_wr_data_i;
  assign rd_valid_o      = (fifo_count_q != '0);
  assign rd_data_o       = fifo_mem[fifo_rd_q];
  assign pop             = rd_valid_o & rd_ready_i;
  assign drain_done      = (state_q == ST_DRAIN) && (fifo_count_q == '0) && (inflight_q == '0);
  assign done_o          = done_q | drain_done;

  // A pop this cycle frees a slot at the same edge, so it counts as a credit.
  assign credit_ok = (32'(fifo_count_q) + 32'(inflight_q)) < (FIFO_DEPTH + 32'(pop));

  // The first read is issued in the accept cycle so the first beat lands RD_LATENCY+1 later.
  always_comb begin
    cur_region = (state_q == ST_IDLE) ? cmd_region_i : region_q;
    base_cur   = region_base_i[32'(cur_region)*ADDR_W +: ADDR_W];
    size_cur   = region_size_i[32'(cur_region)*ADDR_W +: ADDR_W];
    head_cur   = head_q[cur_region];
    ram_addr   = base_cur + head_cur;
    head_adv   = head_cur + 1'b1;
    if (head_adv == size_cur) head_adv = '0;
    rem_cur    = (state_q == ST_IDLE) ? cmd_len_i : remaining_q;
    rd_issue   = credit_ok && (rem_cur != '0) &&
                 (((state_q == ST_IDLE) && cmd_fire && (cmd_op_i == OP_READ)) ||
                  (state_q == ST_READ));
    done_d     = (cmd_fire && ((cmd_op_i == OP_NOP) || (cmd_op_i == OP_PTR_RESET) ||
                               (cmd_len_i == '0))) ||
                 (wr_beat && (remaining_q == LEN_W'(1)));
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire && (cmd_len_i != '0)) begin
          if (cmd_op_i == OP_WRITE)
            state_n = ST_WRITE;
          else if (cmd_op_i == OP_READ)
            state_n = (rd_issue && (cmd_len_i == LEN_W'(1))) ? ST_DRAIN : ST_READ;
        end
      end
      ST_WRITE: if (wr_beat && (remaining_q == LEN_W'(1))) state_n = ST_IDLE;
      ST_READ:  if (rd_issue && (remaining_q == LEN_W'(1))) state_n = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      region_q    <= '0;
      src_q       <= 1'b0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      head_q      <= '{default: '0};
    end else begin
      state_q     <= state_n;
      done_q      <= done_d;
      // Loads len on accept (minus any accept-cycle issue), then counts beats down.
      remaining_q <= rem_cur - LEN_W'(wr_beat | rd_issue);
      if (cmd_fire) begin
        region_q <= cmd_region_i;
        src_q    <= cmd_src_i;
      end
      if (cmd_fire && (cmd_op_i == OP_PTR_RESET))
        head_q[cmd_region_i] <= '0;
      else if (wr_beat || rd_issue)
        head_q[cur_region] <= head_adv;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_count_q <= '0;
      inflight_q   <= '0;
      fifo_wr_q    <= '0;
      fifo_rd_q    <= '0;
    end else begin
      fifo_count_q <= fifo_count_q + CNT_W'(push) - CNT_W'(pop);
      inflight_q   <= inflight_q + CNT_W'(rd_issue) - CNT_W'(push);
      if (push) fifo_wr_q <= (fifo_wr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : fifo_wr_q + 1'b1;
      if (pop)  fifo_rd_q <= (fifo_rd_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : fifo_rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wr_q] <= ram_rdata;
  end

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (fifo_count_q == CNT_W'(FIFO_DEPTH))));

  gbuf_ram #(
    .W          (W),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .RD_LATENCY (RD_LATENCY)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we     (wr_beat),
    .re     (rd_issue),
    .addr   (ram_addr),
    .wdata  (wr_data),
    .rdata  (ram_rdata),
    .rvalid (push)
  );

endmodule

// File: tb/tb_gbuf_burst_ctrl.sv
// Randomised bench for gbuf_burst_ctrl against a word-level memory/pointer reference model.
module tb_gbuf_burst_ctrl;
  import accelerator_package::*;

  localparam int unsigned DATA_W = 8, LANES = 4, W = DATA_W * LANES;
  localparam int unsigned DEPTH = 1024, ADDR_W = 10, NUM_REGIONS = 4, LEN_W = 8, RD_LAT = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid_i = 1'b0, cmd_ready_o, cmd_src_i = 1'b0;
  gbuf_op_t cmd_op_i = OP_NOP;
  logic [1:0] cmd_region_i = '0;
  logic [LEN_W-1:0] cmd_len_i = '0;
  logic [NUM_REGIONS*ADDR_W-1:0] region_base_i, region_size_i;
  logic ext_wr_valid_i = 1'b0, ext_wr_ready_o, obuf_wr_valid_i = 1'b0, obuf_wr_ready_o;
  logic [W-1:0] ext_wr_data_i = '0, obuf_wr_data_i = '0, rd_data_o;
  logic rd_valid_o, rd_ready_i = 1'b0, busy_o, done_o;

  gbuf_burst_ctrl #(
    .DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .NUM_REGIONS(NUM_REGIONS), .LEN_W(LEN_W), .RD_LATENCY(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_src_i(cmd_src_i), .cmd_region_i(cmd_region_i), .cmd_len_i(cmd_len_i),
    .region_base_i(region_base_i), .region_size_i(region_size_i),
    .ext_wr_valid_i(ext_wr_valid_i), .ext_wr_ready_o(ext_wr_ready_o), .ext_wr_data_i(ext_wr_data_i),
    .obuf_wr_valid_i(obuf_wr_valid_i), .obuf_wr_ready_o(obuf_wr_ready_o), .obuf_wr_data_i(obuf_wr_data_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: flat word memory plus per-region head pointers.
  logic [W-1:0] mem_m [DEPTH];
  bit           written [DEPTH];
  int unsigned  head_m [NUM_REGIONS];
  int unsigned  base_m [NUM_REGIONS] = '{0, 200, 1020, 100};
  int unsigned  size_m [NUM_REGIONS] = '{8, 16, 0, 3};

  int unsigned n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int unsigned next_addr(input int unsigned r);
    int unsigned a  = (base_m[r] + head_m[r]) % DEPTH;
    int unsigned sz = (size_m[r] == 0) ? DEPTH : size_m[r];
    head_m[r] = (head_m[r] + 1 == sz) ? 0 : head_m[r] + 1;
    return a;
  endfunction

  task automatic send_cmd(input gbuf_op_t op, input logic src, input int unsigned r,
                          input int unsigned len, output int unsigned acc);
    int unsigned guard = 0;
    @(negedge clk);
    while (!cmd_ready_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready_o) check("cmd_ready_wait", cmd_ready_o, 1);
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_src_i = src;
    cmd_region_i = 2'(r); cmd_len_i = LEN_W'(len);
    acc = cyc;
    @(negedge clk);
    cmd_valid_i = 1'b0; cmd_op_i = OP_NOP;
  endtask

  task automatic do_simple(input gbuf_op_t op, input int unsigned r);
    int unsigned acc;
    send_cmd(op, 1'b0, r, $urandom_range(0, 5), acc);
    if (op == OP_PTR_RESET) head_m[r] = 0;
    check("simple_done", done_o, 1);
    check("simple_busy", busy_o, 0);
    @(negedge clk);
    check("simple_done_off", done_o, 0);
  endtask

  task automatic do_write(input int unsigned r, input logic src, input int unsigned len,
                          input int unsigned bubble_pct, input logic use_seq, input logic [W-1:0] seq0);
    int unsigned acc, a, beats = 0, guard = 0, dones = 0;
    logic v, sel_ready, other_ready;
    logic [W-1:0] d;
    send_cmd(OP_WRITE, src, r, len, acc);
    if (len == 0) begin
      check("wr0_done", done_o, 1);
      @(negedge clk);
      check("wr0_done_off", done_o, 0);
      return;
    end
    while (beats < len && guard < 40 * len + 50) begin
      if (done_o) dones++;
      v = ($urandom_range(99) >= bubble_pct);
      d = use_seq ? seq0 + W'(beats) : W'($urandom);
      ext_wr_valid_i  = !src && v;  ext_wr_data_i  = src ? ~d : d;
      obuf_wr_valid_i =  src && v;  obuf_wr_data_i = src ? d : ~d;
      sel_ready   = src ? obuf_wr_ready_o : ext_wr_ready_o;
      other_ready = src ? ext_wr_ready_o : obuf_wr_ready_o;
      if (v && sel_ready) begin
        check("wr_other_ready", other_ready, 0);
        check("wr_cmd_ready", cmd_ready_o, 0);
        a = next_addr(r);
        mem_m[a] = d;
        written[a] = 1'b1;
        beats++;
      end
      @(negedge clk);
      guard++;
    end
    ext_wr_valid_i = 1'b0; obuf_wr_valid_i = 1'b0;
    if (beats < len) check("wr_timeout", beats, len);
    check("wr_done_early", dones, 0);
    check("wr_done", done_o, 1);
    @(negedge clk);
    check("wr_done_off", done_o, 0);
    check("wr_idle", busy_o, 0);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0, 2: random ready
  task automatic do_read(input int unsigned r, input int unsigned len, input int unsigned mode);
    int unsigned acc, got = 0, guard = 0, dones = 0, k = 0, stray = 0;
    logic [W-1:0] exp_q [$];
    bit known_q [$];
    logic prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    for (int i = 0; i < int'(len); i++) begin
      int unsigned a = next_addr(r);
      exp_q.push_back(mem_m[a]);
      known_q.push_back(written[a]);
    end
    send_cmd(OP_READ, 1'b0, r, len, acc);
    if (len == 0) begin
      check("rd0_done", done_o, 1);
      repeat (5) begin
        if (rd_valid_o) stray++;
        @(negedge clk);
      end
      check("rd0_no_valid", stray, 0);
      return;
    end
    while (got < len && guard < 40 * len + 50) begin
      rd_ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom_range(1));
      k++;
      if (prev_stall) begin
        check("rd_hold_valid", rd_valid_o, 1);
        check("rd_hold_data", rd_data_o, prev_data);
      end
      if (done_o) dones++;
      if (rd_valid_o && got == 0 && mode == 0) check("rd_first_lat", cyc - acc, RD_LAT + 1);
      if (rd_valid_o && rd_ready_i) begin
        if (known_q[got]) check("rd_data", rd_data_o, exp_q[got]);
        got++;
      end
      prev_stall = rd_valid_o && !rd_ready_i;
      prev_data  = rd_data_o;
      @(negedge clk);
      guard++;
    end
    if (got < len) check("rd_timeout", got, len);
    check("rd_done_early", dones, 0);
    check("rd_done", done_o, 1);
    rd_ready_i = 1'b1;
    @(negedge clk);
    check("rd_done_off", done_o, 0);
    check("rd_idle", busy_o, 0);
    check("rd_no_extra", rd_valid_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned acc, stale;
    for (int i = 0; i < int'(NUM_REGIONS); i++) begin
      region_base_i[i*ADDR_W +: ADDR_W] = ADDR_W'(base_m[i]);
      region_size_i[i*ADDR_W +: ADDR_W] = ADDR_W'(size_m[i]);
      head_m[i] = 0;
    end
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_rd_valid", rd_valid_o, 0);
    check("rst_wr_ready", {ext_wr_ready_o, obuf_wr_ready_o}, 0);
    rst = 1'b0;

    // basic write/read, latency and done pulse
    do_write(0, 1'b0, 4, 0, 1'b1, '0);
    do_simple(OP_PTR_RESET, 0);
    do_read(0, 4, 0);

    // circular region: base 100, size 3, five beats; head lands on 2
    do_write(3, 1'b0, 5, 0, 1'b0, '0);
    do_read(3, 3, 0);

    // backpressure with 1,0,0 ready pattern
    do_simple(OP_PTR_RESET, 1);
    do_write(1, 1'b0, 10, 0, 1'b0, '0);
    do_simple(OP_PTR_RESET, 1);
    do_read(1, 10, 1);

    // OBUF with bubbles into region 2 (wraps past the top of memory)
    do_write(2, 1'b1, 6, 40, 1'b0, '0);
    do_simple(OP_PTR_RESET, 2);
    do_read(2, 6, 2);

    // pointer reset after three writes, then a single-beat read and empty bursts
    do_simple(OP_PTR_RESET, 1);
    do_write(1, 1'b0, 3, 0, 1'b0, '0);
    do_simple(OP_PTR_RESET, 1);
    do_read(1, 1, 0);
    do_read(1, 0, 0);
    do_write(1, 1'b0, 0, 0, 1'b0, '0);
    do_simple(OP_NOP, 0);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      int unsigned sel = $urandom_range(9), r = $urandom_range(NUM_REGIONS - 1);
      int unsigned len = $urandom_range(0, 12);
      if (sel == 0)      do_simple(OP_NOP, r);
      else if (sel == 1) do_simple(OP_PTR_RESET, r);
      else if (sel < 6)  do_write(r, 1'($urandom_range(1)), len, 30, 1'b0, '0);
      else               do_read(r, len, $urandom_range(2));
    end

    // reset in the middle of a read with data in flight
    send_cmd(OP_READ, 1'b0, 0, 8, acc);
    rd_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_valid", rd_valid_o, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", rd_valid_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_cmd_ready", cmd_ready_o, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < int'(NUM_REGIONS); i++) head_m[i] = 0;
    check("post_rst_cmd_ready", cmd_ready_o, 1);
    rd_ready_i = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (rd_valid_o) stale++;
    end
    check("post_rst_stale", stale, 0);
    do_read(0, 3, 0);
    do_read(3, 2, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
